alu_acc_seq: RTL and testbench

- Parametrised, clocked successor to the 8-bit combinational accumulator ALU.
- Holds the accumulator internally and accepts one operation per start handshake.
- Adds a multi-cycle shift-add multiply, status flags and busy/done handshaking.
- Sits between the instruction decoder (drives op/data/start) and the register/bus logic (consumes accum and flags).

---
 rtl/alu_acc_seq.sv | 158 +++++++++++++++
 tb/tb_alu_acc_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_seq.sv
// Sequential accumulator ALU with shift-add multiply and busy/done handshake.
// Define ALU_SAT_EN to saturate ADD/SUB/MUL results instead of wrapping.
module alu_acc_seq #(
  parameter int n  = 8,
  parameter int CW = $clog2(n) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [n-1:0] data,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] accum,
  output logic         zero,
  output logic         carry
);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  state_t         state;
  logic [n-1:0]   mplier;
  logic [2*n-1:0] mcand_sh;
  logic [2*n-1:0] prod;
  logic [CW-1:0]  cnt;

  logic [n:0]     sum;
  logic [n:0]     diff;
  logic [n-1:0]   alu_res;
  logic           alu_c;
  logic [2*n-1:0] prod_next;
  logic [n-1:0]   mul_res;
  logic           mul_ovf;

  // Single-cycle result; the borrow of SUB falls out as bit n of the extended difference.
  always_comb begin
    sum     = {1'b0, accum} + {1'b0, data};
    diff    = {1'b0, accum} - {1'b0, data};
    alu_res = accum;
    alu_c   = carry;
    case (op)
      OP_NOP: begin
        alu_res = accum;
        alu_c   = carry;
      end
      OP_ADD: begin
        alu_res = sum[n-1:0];
        alu_c   = sum[n];
`ifdef ALU_SAT_EN
        if (sum[n]) alu_res = '1;
`endif
      end
      OP_SUB: begin
        alu_res = diff[n-1:0];
        alu_c   = diff[n];
`ifdef ALU_SAT_EN
        if (diff[n]) alu_res = '0;
`endif
      end
      OP_AND: begin
        alu_res = accum & data;
        alu_c   = 1'b0;
      end
      OP_XOR: begin
        alu_res = accum ^ data;
        alu_c   = 1'b0;
      end
      OP_LOAD: begin
        alu_res = data;
        alu_c   = 1'b0;
      end
      OP_SHR: begin
        alu_res = {1'b0, accum[n-1:1]};
        alu_c   = accum[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    prod_next = mplier[0] ? prod + mcand_sh : prod;
    mul_ovf   = |prod_next[2*n-1:n];
    mul_res   = prod_next[n-1:0];
`ifdef ALU_SAT_EN
    if (mul_ovf) mul_res = '1;
`endif
  end

  // The multiplicand shifts left and the multiplier right, so bit 0 always selects the add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      accum    <= '0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mplier   <= '0;
      mcand_sh <= '0;
      prod     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op == OP_MUL) begin
              state    <= MUL;
              mcand_sh <= {{n{1'b0}}, accum};
              mplier   <= data;
              prod     <= '0;
              cnt      <= '0;
            end else begin
              state <= FIN;
              done  <= 1'b1;
              accum <= alu_res;
              carry <= alu_c;
              zero  <= (alu_res == '0);
            end
          end
        end
        MUL: begin
          prod     <= prod_next;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(n - 1)) begin
            state <= FIN;
            done  <= 1'b1;
            accum <= mul_res;
            carry <= mul_ovf;
            zero  <= (mul_res == '0);
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq at n=8 and n=16; honours ALU_SAT_EN for expectations.
module tb_alu_acc_seq;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] SUB  = 3'b010;
  localparam logic [2:0] ANDO = 3'b011;
  localparam logic [2:0] XORO = 3'b100;
  localparam logic [2:0] LOAD = 3'b101;
  localparam logic [2:0] MULO = 3'b110;
  localparam logic [2:0] SHR  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [2:0]  op8, op16;
  logic [7:0]  data8;
  logic [15:0] data16;
  logic        busy8, done8, zero8, carry8;
  logic        busy16, done16, zero16, carry16;
  logic [7:0]  accum8;
  logic [15:0] accum16;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic [15:0] cur_accum;
  logic        cur_busy, cur_done, cur_zero, cur_carry;

  assign cur_accum = sel ? accum16 : {8'h00, accum8};
  assign cur_busy  = sel ? busy16  : busy8;
  assign cur_done  = sel ? done16  : done8;
  assign cur_zero  = sel ? zero16  : zero8;
  assign cur_carry = sel ? carry16 : carry8;

  always #5 clk = ~clk;

  alu_acc_seq #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .data(data8),
    .busy(busy8), .done(done8), .accum(accum8), .zero(zero8), .carry(carry8)
  );

  alu_acc_seq #(.n(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .data(data16),
    .busy(busy16), .done(done16), .accum(accum16), .zero(zero16), .carry(carry16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and waits (bounded) for done; latency counts cycles after acceptance.
  task automatic applyStimulus(input bit wide, input logic [2:0] o, input logic [15:0] d,
                               output int lat);
    sel = wide;
    @(negedge clk);
    if (wide) begin
      start16 = 1'b1; op16 = o; data16 = d;
    end else begin
      start8 = 1'b1; op8 = o; data8 = d[7:0];
    end
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
    lat = 1;
    while (!cur_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runCheck(input string tag, input bit wide, input logic [2:0] o,
                          input logic [15:0] d, input int exp_lat, input logic [15:0] exp_acc,
                          input logic exp_c, input logic exp_z);
    int lat;
    applyStimulus(wide, o, d, lat);
    checkOutput({tag, "_lat"},   lat, exp_lat);
    checkOutput({tag, "_busy"},  cur_busy, 1'b1);
    checkOutput({tag, "_accum"}, cur_accum, exp_acc);
    checkOutput({tag, "_carry"}, cur_carry, exp_c);
    checkOutput({tag, "_zero"},  cur_zero, exp_z);
    @(posedge clk); #1;
    checkOutput({tag, "_done_off"}, cur_done, 1'b0);
    checkOutput({tag, "_busy_off"}, cur_busy, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b1;
    start8 = 1'b0; op8 = NOP; data8 = '0;
    start16 = 1'b0; op16 = NOP; data16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst8_accum", accum8, 8'h00);
    checkOutput("rst8_zero",  zero8, 1'b1);
    checkOutput("rst8_carry", carry8, 1'b0);
    checkOutput("rst8_busy",  busy8, 1'b0);
    checkOutput("rst8_done",  done8, 1'b0);
    checkOutput("rst16_accum", accum16, 16'h0000);
    checkOutput("rst16_zero",  zero16, 1'b1);
    checkOutput("rst16_busy",  busy16, 1'b0);

    runCheck("ld7f",   0, LOAD, 16'h7F, 1, 16'h7F, 1'b0, 1'b0);
    runCheck("add01",  0, ADD,  16'h01, 1, 16'h80, 1'b0, 1'b0);
    runCheck("add80",  0, ADD,  16'h80, 1, SAT ? 16'hFF : 16'h00, 1'b1, !SAT);
    runCheck("nop",    0, NOP,  16'h5A, 1, SAT ? 16'hFF : 16'h00, 1'b1, !SAT);
    runCheck("ld00",   0, LOAD, 16'h00, 1, 16'h00, 1'b0, 1'b1);
    runCheck("sub01",  0, SUB,  16'h01, 1, SAT ? 16'h00 : 16'hFF, 1'b1, SAT);
    runCheck("shr",    0, SHR,  16'h00, 1, SAT ? 16'h00 : 16'h7F, !SAT, SAT);
    runCheck("and3c",  0, ANDO, 16'h3C, 1, SAT ? 16'h00 : 16'h3C, 1'b0, SAT);
    runCheck("xorff",  0, XORO, 16'hFF, 1, SAT ? 16'hFF : 16'hC3, 1'b0, 1'b0);
    runCheck("ld0c",   0, LOAD, 16'h0C, 1, 16'h0C, 1'b0, 1'b0);
    runCheck("mul0b",  0, MULO, 16'h0B, 9, 16'h84, 1'b0, 1'b0);
    runCheck("ld10",   0, LOAD, 16'h10, 1, 16'h10, 1'b0, 1'b0);
    runCheck("mul10",  0, MULO, 16'h10, 9, SAT ? 16'hFF : 16'h00, 1'b1, !SAT);

    // A LOAD pulsed mid-multiply and again during FIN must both be dropped.
    runCheck("ld0c_b", 0, LOAD, 16'h0C, 1, 16'h0C, 1'b0, 1'b0);
    sel = 1'b0;
    @(negedge clk);
    start8 = 1'b1; op8 = MULO; data8 = 8'h0B;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      if (lat == 3) begin
        start8 = 1'b1; op8 = LOAD; data8 = 8'h55;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      lat++;
    end
    checkOutput("ign_lat",   lat, 9);
    checkOutput("ign_accum", accum8, 8'h84);
    checkOutput("ign_carry", carry8, 1'b0);
    start8 = 1'b1; op8 = LOAD; data8 = 8'h55;
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("fin_ign_done",  done8, 1'b0);
    checkOutput("fin_ign_busy",  busy8, 1'b0);
    checkOutput("fin_ign_accum", accum8, 8'h84);
    @(posedge clk); #1;
    checkOutput("fin_ign_accum2", accum8, 8'h84);
    checkOutput("fin_ign_busy2",  busy8, 1'b0);

    // Reset during the 4th multiply iteration clears at once and leaves no done behind.
    @(negedge clk);
    start8 = 1'b1; op8 = MULO; data8 = 8'h0B;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midmul_busy", busy8, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_accum", accum8, 8'h00);
    checkOutput("midrst_zero",  zero8, 1'b1);
    checkOutput("midrst_carry", carry8, 1'b0);
    checkOutput("midrst_busy",  busy8, 1'b0);
    checkOutput("midrst_done",  done8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    checkOutput("midrst_no_done", pulses, 0);

    runCheck("w_ldffff", 1, LOAD, 16'hFFFF, 1, 16'hFFFF, 1'b0, 1'b0);
    runCheck("w_add1",   1, ADD,  16'h0001, 1, SAT ? 16'hFFFF : 16'h0000, 1'b1, !SAT);
    runCheck("w_ld0",    1, LOAD, 16'h0000, 1, 16'h0000, 1'b0, 1'b1);
    runCheck("w_sub1",   1, SUB,  16'h0001, 1, SAT ? 16'h0000 : 16'hFFFF, 1'b1, SAT);
    runCheck("w_ld100",  1, LOAD, 16'h0100, 1, 16'h0100, 1'b0, 1'b0);
    runCheck("w_mul100", 1, MULO, 16'h0100, 17, SAT ? 16'hFFFF : 16'h0000, 1'b1, !SAT);
    runCheck("w_ldff",   1, LOAD, 16'h00FF, 1, 16'h00FF, 1'b0, 1'b0);
    runCheck("w_mul3",   1, MULO, 16'h0003, 17, 16'h02FD, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
